// File: rtl/shot_buzz_if.sv
// Signal bundle between the button / shot-counter side and shot_buzz_ctrl.
// The controller takes the slave view; the surrounding logic takes the master view.
interface shot_buzz_if #(
  parameter int CNT_W = 4
);
  logic             shoot_btn;
  logic [CNT_W-1:0] count;
  logic             shoot;
  logic             buzz;
  logic             expired;

  modport master (
    output shoot_btn,
    output count,
    input  shoot,
    input  buzz,
    input  expired
  );

  modport slave (
    input  shoot_btn,
    input  count,
    output shoot,
    output buzz,
    output expired
  );
endinterface

// File: rtl/shot_buzz_ctrl.sv
// Conditions the shoot button into a one-cycle pulse and drives the buzz window /
// expired flag from the shot-clock count. All outputs come straight from flops.
module shot_buzz_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int BUZZ_CYCLES     = 8,
  parameter int CNT_W           = 4
) (
  input  logic       clk,
  input  logic       rst,
  shot_buzz_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    BUZZ = 2'b10,
    DONE = 2'b11
  } state_t;

  // Terminal values: the counters stop one short so that the level change and
  // the buzz window land exactly on the configured cycle counts.
  localparam logic [7:0] DEB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] BUZZ_LOAD = 8'(BUZZ_CYCLES - 1);

  logic       sync_meta_r;
  logic       btn_sync_r;
  logic       btn_deb_r;
  logic [7:0] deb_cnt_r;
  logic       shoot_r;

  logic       deb_level_nxt_s;
  logic [7:0] deb_cnt_nxt_s;

  state_t     state_r;
  state_t     state_nxt_s;
  logic [7:0] buzz_cnt_r;
  logic [7:0] buzz_cnt_nxt_s;
  logic       buzz_r;
  logic       buzz_nxt_s;
  logic       expired_r;
  logic       expired_nxt_s;

  // Debounce: level follows the synchronized button once it has differed long enough
  always_comb begin
    deb_level_nxt_s = btn_deb_r;
    deb_cnt_nxt_s   = 8'd0;
    if (btn_sync_r == btn_deb_r) begin
      deb_cnt_nxt_s = 8'd0;
    end else if (deb_cnt_r == DEB_LAST) begin
      deb_level_nxt_s = btn_sync_r;
      deb_cnt_nxt_s   = 8'd0;
    end else begin
      deb_cnt_nxt_s = deb_cnt_r + 8'd1;
    end
  end

  // Synchronizer, debounce state and rising-edge shoot pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta_r <= 1'b0;
      btn_sync_r  <= 1'b0;
      btn_deb_r   <= 1'b0;
      deb_cnt_r   <= 8'd0;
      shoot_r     <= 1'b0;
    end else begin
      sync_meta_r <= bus.shoot_btn;
      btn_sync_r  <= sync_meta_r;
      btn_deb_r   <= deb_level_nxt_s;
      deb_cnt_r   <= deb_cnt_nxt_s;
      shoot_r     <= deb_level_nxt_s & ~btn_deb_r;
    end
  end

  // Expiry FSM next state; the registered shoot pulse is what the shot counter sees,
  // so the FSM reacts to that same pulse. Shoot outranks the buzz terminal count.
  always_comb begin
    state_nxt_s    = state_r;
    buzz_cnt_nxt_s = buzz_cnt_r;
    buzz_nxt_s     = 1'b0;
    expired_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.count != {CNT_W{1'b0}}) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (shoot_r) begin
          state_nxt_s = RUN;
        end else if (bus.count == {CNT_W{1'b0}}) begin
          state_nxt_s    = BUZZ;
          buzz_cnt_nxt_s = BUZZ_LOAD;
          buzz_nxt_s     = 1'b1;
        end else begin
          state_nxt_s = RUN;
        end
      end
      BUZZ: begin
        if (shoot_r) begin
          state_nxt_s = IDLE;
        end else if (buzz_cnt_r == 8'd0) begin
          state_nxt_s   = DONE;
          expired_nxt_s = 1'b1;
        end else begin
          state_nxt_s    = BUZZ;
          buzz_cnt_nxt_s = buzz_cnt_r - 8'd1;
          buzz_nxt_s     = 1'b1;
        end
      end
      DONE: begin
        if (shoot_r) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s   = DONE;
          expired_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state, buzz counter and registered buzz/expired outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      buzz_cnt_r <= 8'd0;
      buzz_r     <= 1'b0;
      expired_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      buzz_cnt_r <= buzz_cnt_nxt_s;
      buzz_r     <= buzz_nxt_s;
      expired_r  <= expired_nxt_s;
    end
  end

  assign bus.shoot   = shoot_r;
  assign bus.buzz    = buzz_r;
  assign bus.expired = expired_r;

endmodule

// File: tb/tb_shot_buzz_ctrl.sv
// Scoreboard bench for shot_buzz_ctrl: a cycle-level reference model queues the expected
// {shoot, buzz, expired} each edge, a monitor compares on the falling edge.
module tb_shot_buzz_ctrl;
  localparam int DEB = 4;
  localparam int BZ  = 8;
  localparam int CW  = 4;

  logic clk = 1'b0;
  logic rst;

  shot_buzz_if #(.CNT_W(CW)) bus ();

  shot_buzz_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .BUZZ_CYCLES    (BZ),
    .CNT_W          (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2:0] exp_q[$];
  int cyc_no = 0;

  // Directed-phase observations, owned by the stimulus process only
  int w_idx, w_shoot, w_buzz, w_exp, fs, fb, fx;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic clr();
    w_idx = 0; w_shoot = 0; w_buzz = 0; w_exp = 0; fs = 0; fb = 0; fx = 0;
  endtask

  // Advance n cycles, sampling outputs on each falling edge
  task automatic watch(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      w_idx++;
      if (bus.shoot) begin w_shoot++; if (fs == 0) fs = w_idx; end
      if (bus.buzz) begin w_buzz++; if (fb == 0) fb = w_idx; end
      if (bus.expired) w_exp++;
      if (!bus.expired && fx == 0) fx = w_idx;
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Reference model: debounced level flips once the last DEB synchronized samples all
  // disagree with it; the buzz window is a countdown of BZ cycles.
  initial begin : model
    bit hist[$];
    bit lvl, m_shoot, prev_shoot, flip, m_exp, running;
    int buzz_left;
    lvl = 1'b0; m_shoot = 1'b0; m_exp = 1'b0; running = 1'b0; buzz_left = 0;
    for (int i = 0; i < DEB + 2; i++) hist.push_back(1'b0);
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < DEB + 2; i++) hist[i] = 1'b0;
        lvl = 1'b0; m_shoot = 1'b0; m_exp = 1'b0; running = 1'b0; buzz_left = 0;
      end else begin
        hist.push_back(bus.shoot_btn);
        void'(hist.pop_front());
        flip = 1'b1;
        for (int i = 0; i < DEB; i++) if (hist[i] == lvl) flip = 1'b0;
        prev_shoot = m_shoot;
        m_shoot = flip && !lvl;
        if (flip) lvl = !lvl;
        if (buzz_left > 0) begin
          if (prev_shoot) buzz_left = 0;
          else begin
            buzz_left--;
            if (buzz_left == 0) m_exp = 1'b1;
          end
        end else if (m_exp) begin
          if (prev_shoot) m_exp = 1'b0;
        end else if (running) begin
          if (!prev_shoot && bus.count == 0) begin
            buzz_left = BZ;
            running = 1'b0;
          end
        end else if (bus.count != 0) begin
          running = 1'b1;
        end
      end
      exp_q.push_back({m_shoot, (buzz_left > 0), m_exp});
    end
  end

  // Monitor: compare every output cycle against the queued expectation
  initial begin : monitor
    logic [2:0] e, a;
    forever begin
      @(negedge clk);
      cyc_no++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {bus.shoot, bus.buzz, bus.expired};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL scoreboard cycle %0d: shoot/buzz/expired got %b required %b", cyc_no, a, e);
        end
      end
    end
  end

  initial begin : stim
    int hold;
    hold = 0;
    rst = 1'b1; bus.shoot_btn = 1'b0; bus.count = 4'd0;
    clr();
    watch(1);

    // Reset held with active-looking inputs
    bus.count = 4'd5; bus.shoot_btn = 1'b1;
    clr(); watch(3);
    check("reset_outputs_quiet", w_shoot + w_buzz + w_exp, 0);
    rst = 1'b0; bus.shoot_btn = 1'b0;
    watch(20);

    // Bounce rejection
    clr();
    for (int k = 0; k < 10; k++) begin
      bus.shoot_btn = ~bus.shoot_btn;
      watch(2);
    end
    bus.shoot_btn = 1'b0;
    watch(10);
    check("bounce_no_shoot", w_shoot, 0);

    // Clean press and release
    clr(); bus.shoot_btn = 1'b1; watch(40);
    bus.shoot_btn = 1'b0; watch(20);
    check("press_pulse_cycles", w_shoot, 1);
    check("press_latency", fs, DEB + 2);

    // Expiry
    bus.count = 4'd3; watch(10);
    bus.count = 4'd2; watch(10);
    bus.count = 4'd1; watch(10);
    clr(); bus.count = 4'd0; watch(30);
    check("expiry_buzz_start", fb, 1);
    check("expiry_buzz_len", w_buzz, BZ);
    check("expiry_expired_held", w_exp, 30 - BZ);
    clr(); bus.shoot_btn = 1'b1; watch(12);
    bus.shoot_btn = 1'b0; watch(20);
    check("clear_shoot_at", fs, DEB + 2);
    check("clear_expired_at", fx, DEB + 3);
    check("clear_expired_len", w_exp, DEB + 2);

    // Abort by a shoot pulse in the third buzz cycle
    bus.count = 4'd4; watch(10);
    bus.shoot_btn = 1'b1; watch(3);
    clr(); bus.count = 4'd0; watch(20);
    bus.shoot_btn = 1'b0; watch(20);
    check("abort_shoot_at", fs, 3);
    check("abort_buzz_len", w_buzz, 3);
    check("abort_no_expired", w_exp, 0);

    // Reset in the fourth buzz cycle
    bus.count = 4'd6; watch(5);
    clr(); bus.count = 4'd0; watch(4);
    rst = 1'b1; watch(1);
    rst = 1'b0;
    check("rst_mid_buzz_len", w_buzz, 4);
    clr(); watch(20);
    check("rst_no_rebuzz", w_buzz + w_exp, 0);
    bus.count = 4'd2; watch(5);
    clr(); bus.count = 4'd0; watch(20);
    check("rearm_buzz_start", fb, 1);
    check("rearm_buzz_len", w_buzz, BZ);

    // Randomized traffic, scoreboard only
    for (int c = 0; c < 1500; c++) begin
      if (hold == 0) begin
        bus.shoot_btn = 1'($urandom_range(0, 1));
        hold = int'($urandom_range(1, 10));
      end
      hold--;
      if ($urandom_range(0, 11) == 0)
        bus.count = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      rst = ($urandom_range(0, 249) == 0);
      cyc(1);
    end
    rst = 1'b0;
    cyc(3);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shot_buzz_ctrl.md
# shot_buzz_ctrl

Control stage directly upstream of the `shot` shot-clock counter. It conditions the raw shoot push-button into a clean one-cycle `shoot` pulse, and it watches the `count` value that `shot` returns. It drives the `buzz` input of `shot` for a fixed window when the shot clock expires. It also holds an `expired` flag until the next shot is taken.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before the debounced button level changes (range 1..255).
- `BUZZ_CYCLES`, default 8: length of the buzz window in clock cycles (range 1..255).
- `CNT_W`, default 4: width of the `count` input.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `shoot_btn`  in  1  raw, asynchronous, bouncy push-button.
- `count`  in  CNT_W  current shot-clock value from `shot`.
- `shoot`  out  1  one-cycle pulse to `shot.shoot`, registered.
- `buzz`  out  1  buzzer drive to `shot.buzz`, registered.
- `expired`  out  1  level; high from the end of the buzz window until the next `shoot`.

## Operation
Button path:
- Two-flop synchronizer on `shoot_btn` produces `btn_s`.
- Debounce counter (8 bit):
  - Clears whenever `btn_s` equals the debounced level `btn_d`.
  - Increments while `btn_s` differs from `btn_d`.
  - When it reaches `DEBOUNCE_CYCLES`, `btn_d` takes `btn_s` and the counter clears.
- `shoot` = 1 for exactly the cycle following a 0->1 transition of `btn_d`.
- The 1->0 transition of `btn_d` produces no pulse.
- Holding the button produces one pulse only.

Expiry FSM, states IDLE, RUN, BUZZ, DONE:
- IDLE: `buzz`=0, `expired`=0. Go to RUN when `count` != 0.
- RUN: go to BUZZ when `count` == 0.
  - Load the buzz counter with `BUZZ_CYCLES`-1.
  - Register `buzz`=1.
  - A `shoot` pulse while in RUN keeps the state in RUN.
- BUZZ: `buzz`=1.
  - Decrement the buzz counter each cycle.
  - When the counter is 0, go to DONE with `buzz`=0 and `expired`=1.
  - A `shoot` pulse in BUZZ aborts: go to IDLE, `buzz`=0 on the next cycle.
  - A `shoot` pulse takes priority over counter terminal.
- DONE: `expired`=1. A `shoot` pulse goes to IDLE, with `expired`=0 on the next cycle.
- `count` changing while in BUZZ or DONE is ignored.
- Only a `shoot` pulse leaves BUZZ early or leaves DONE.
- Unreachable state encodings return to IDLE.

Reset (`rst`=1 at a rising edge):
- State goes to IDLE.
- Synchronizer flops, `btn_d`, the debounce counter and the buzz counter all go to 0.
- `shoot`=0, `buzz`=0, `expired`=0.
- Reset mid-buzz or mid-debounce discards all progress.
- Reset takes priority over every other event.

## Timing
- Button latency:
  - `shoot_btn` is high and stable before rising edge E0.
  - `btn_s` is high after E1.
  - `btn_d` rises and `shoot` goes high at edge E(1+`DEBOUNCE_CYCLES`).
  - `shoot` is low again after the next edge.
  - With the default of 4: `shoot` is high in the cycle after E5.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles at `btn_s` produces no pulse.
- Buzz timing:
  - `buzz` rises at the first edge at which the FSM is in RUN and samples `count`==0.
  - `buzz` stays high for exactly `BUZZ_CYCLES` cycles.
  - `expired` rises at the same edge at which `buzz` falls.
- Abort: a `shoot` pulse sampled at edge E clears `buzz` (or `expired`) at edge E+1.
- Outputs are registered only: no combinational paths from inputs to outputs.

## Test plan
- Reset check: assert `rst` for 3 cycles with `count`=5 and `shoot_btn`=1 → `shoot`, `buzz`, `expired` = 0 throughout; FSM reaches RUN only after `rst` falls.
- Bounce rejection: toggle `shoot_btn` 1/0 every 2 cycles for 20 cycles, default parameters → `shoot` never asserts.
- Clean press: `shoot_btn` held high for 40 cycles → exactly one `shoot` pulse, 1 cycle wide, high in the cycle after the 6th rising edge; no pulse on release.
- Expiry: drive `count` 3,2,1,0 (one value every 10 cycles) → `buzz` high for exactly 8 cycles starting at the edge after `count`=0 is sampled; then `expired`=1 and held; a later clean press clears `expired` one cycle after `shoot`.
- Abort: expiry as above, with a `shoot` pulse landing in the 3rd buzz cycle → `buzz` drops the next cycle; `expired` stays 0; state IDLE.
- Reset mid-buzz: `rst` pulsed in the 4th buzz cycle → `buzz`=0 next cycle; after release with `count`=0 held, no new buzz until `count` becomes nonzero and returns to 0.
